// File: rtl/aes_pkg.sv
// aes_pkg: shared byte counts and enums for the S-box sharing controller
package aes_pkg;
  localparam int STATE_BYTES = 16;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW, RESP} sbox_share_state_t;
  typedef enum logic {GRANT_ST, GRANT_KW} sbox_grant_t;
endpackage

// File: rtl/sbox_chunk_mux.sv
// sbox_chunk_mux: picks the lane input bytes for a chunk and merges lane outputs back into the buffer image
module sbox_chunk_mux
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4,
  parameter int CW = 2
) (
  input  logic [8*STATE_BYTES-1:0] buf_q,
  input  logic [CW-1:0]            chunk,
  input  logic [8*NUM_SBOX-1:0]    sb_out,
  output logic [8*NUM_SBOX-1:0]    lane_in,
  output logic [8*STATE_BYTES-1:0] merged
);
  // Lane j serves buffer byte chunk*NUM_SBOX+j; byte 0 is the most significant byte
  always_comb begin
    lane_in = '0;
    merged = buf_q;
    for (int j = 0; j < NUM_SBOX; j++) begin
      lane_in[8*j +: 8] = buf_q[8*(STATE_BYTES-1-(int'(chunk)*NUM_SBOX+j)) +: 8];
      merged[8*(STATE_BYTES-1-(int'(chunk)*NUM_SBOX+j)) +: 8] = sb_out[8*j +: 8];
    end
  end
endmodule

// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-multiplexes NUM_SBOX shared S-box lanes between SubBytes and SubWord requesters; SBOX_SHARE_PERF_CNT_EN enables the busy_cycles counter
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_req_valid,
  output logic                  st_req_ready,
  input  logic [127:0]          st_req_data,
  output logic                  st_resp_valid,
  output logic [127:0]          st_resp_data,
  input  logic                  kw_req_valid,
  output logic                  kw_req_ready,
  input  logic [31:0]           kw_req_data,
  output logic                  kw_resp_valid,
  output logic [31:0]           kw_resp_data,
  output logic [8*NUM_SBOX-1:0] sb_in,
  input  logic [8*NUM_SBOX-1:0] sb_out,
  output logic [31:0]           busy_cycles
);
  localparam int ST_C = STATE_BYTES / NUM_SBOX;
  localparam int KW_C = WORD_BYTES / NUM_SBOX;
  localparam int CW = (ST_C > 1) ? $clog2(ST_C) : 1;
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("sbox_share_ctrl: NUM_SBOX must be 1, 2 or 4");
  end
  sbox_share_state_t state;
  sbox_grant_t last_grant;
  logic rdy, run, last, take_st, take_kw;
  logic [CW-1:0] chunk;
  logic [127:0] buf_q, merged;
  logic [8*NUM_SBOX-1:0] lane_in;
  assign run = state == RUN_ST || state == RUN_KW;
  assign last = chunk == (state == RUN_ST ? CW'(ST_C - 1) : CW'(KW_C - 1));
  assign take_st = rdy && st_req_valid && (!kw_req_valid || last_grant == GRANT_KW);
  assign take_kw = rdy && kw_req_valid && !take_st;
  assign st_req_ready = rdy;
  assign kw_req_ready = rdy;
  assign sb_in = run ? lane_in : '0;
  sbox_chunk_mux #(.NUM_SBOX(NUM_SBOX), .CW(CW)) u_mux (
    .buf_q(buf_q),
    .chunk(chunk),
    .sb_out(sb_out),
    .lane_in(lane_in),
    .merged(merged)
  );
  // Accept one request per edge, run its chunks through the lanes, then pulse the matching response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= GRANT_KW;
      rdy <= 1'b0;
      chunk <= '0;
      buf_q <= '0;
      st_resp_valid <= 1'b0;
      kw_resp_valid <= 1'b0;
      st_resp_data <= '0;
      kw_resp_data <= '0;
    end else begin
      st_resp_valid <= 1'b0;
      kw_resp_valid <= 1'b0;
      if (take_st || take_kw) begin
        state <= take_st ? RUN_ST : RUN_KW;
        last_grant <= take_st ? GRANT_ST : GRANT_KW;
        buf_q <= take_st ? st_req_data : {kw_req_data, 96'h0};
        rdy <= 1'b0;
      end else if (run) begin
        buf_q <= merged;
        chunk <= last ? '0 : chunk + 1'b1;
        if (last) begin
          state <= RESP;
          rdy <= 1'b1;
          st_resp_valid <= state == RUN_ST;
          kw_resp_valid <= state == RUN_KW;
          if (state == RUN_ST) st_resp_data <= merged;
          else kw_resp_data <= merged[127:96];
        end
      end else begin
        state <= IDLE;
        rdy <= 1'b1;
      end
    end
  end
`ifdef SBOX_SHARE_PERF_CNT_EN
  // Count cycles spent driving the lanes, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cycles <= '0;
    else if (run && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
  end
`else
  assign busy_cycles = '0;
`endif
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb_sbox_share_ctrl: scoreboard bench for sbox_share_ctrl with 4-lane and 1-lane instances
module tb_sbox_share_ctrl;
  typedef struct {
    int d;
    bit kw;
    logic [127:0] data;
    int lat;
  } exp_t;
  localparam logic [127:0] X = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SX = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] W = {32'h09cf4f3c, 96'h0};
  localparam logic [127:0] SW = {32'h018a84eb, 96'h0};
  localparam logic [127:0] X2 = 128'h0;
  localparam logic [127:0] SX2 = {16{8'h63}};
  localparam logic [127:0] W2 = {32'hffffffff, 96'h0};
  localparam logic [127:0] SW2 = {32'h16161616, 96'h0};
`ifdef SBOX_SHARE_PERF_CNT_EN
  localparam logic [31:0] BUSY_EXP = 32'd5;
`else
  localparam logic [31:0] BUSY_EXP = 32'd0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic st_v[2], st_r[2], st_rv[2], kw_v[2], kw_r[2], kw_rv[2];
  logic [127:0] st_d[2], st_rd[2];
  logic [31:0] kw_d[2], kw_rd[2], busy[2];
  logic [31:0] sb_in0, sb_out0;
  logic [7:0] sb_in1, sb_out1;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  int acc_cnt[2] = '{0, 0};
  int acc_cyc[2] = '{0, 0};
  int prev_acc[2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v = 8'h0;
    for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  always_comb for (int j = 0; j < 4; j++) sb_out0[8*j +: 8] = sbox(sb_in0[8*j +: 8]);
  always_comb sb_out1 = sbox(sb_in1);

  sbox_share_ctrl #(.NUM_SBOX(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_v[0]), .st_req_ready(st_r[0]), .st_req_data(st_d[0]),
    .st_resp_valid(st_rv[0]), .st_resp_data(st_rd[0]),
    .kw_req_valid(kw_v[0]), .kw_req_ready(kw_r[0]), .kw_req_data(kw_d[0]),
    .kw_resp_valid(kw_rv[0]), .kw_resp_data(kw_rd[0]),
    .sb_in(sb_in0), .sb_out(sb_out0), .busy_cycles(busy[0])
  );
  sbox_share_ctrl #(.NUM_SBOX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_v[1]), .st_req_ready(st_r[1]), .st_req_data(st_d[1]),
    .st_resp_valid(st_rv[1]), .st_resp_data(st_rd[1]),
    .kw_req_valid(kw_v[1]), .kw_req_ready(kw_r[1]), .kw_req_data(kw_d[1]),
    .kw_resp_valid(kw_rv[1]), .kw_resp_data(kw_rd[1]),
    .sb_in(sb_in1), .sb_out(sb_out1), .busy_cycles(busy[1])
  );

  // Monitor: responses are matched against the scoreboard before this cycle's accept is logged
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (st_rv[d] || kw_rv[d]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d: st_valid=%0b kw_valid=%0b, none expected", d, st_rv[d], kw_rv[d]);
        end else begin
          e = exp_q.pop_front();
          if (e.d != d || e.kw != kw_rv[d] || (st_rv[d] && kw_rv[d]) ||
              (st_rv[d] ? st_rd[d] : {kw_rd[d], 96'h0}) != e.data || cyc - acc_cyc[d] != e.lat) begin
            errors++;
            $display("FAIL resp dut%0d: got kw=%0b st=%0b data=%h lat=%0d, expected dut%0d kw=%0b data=%h lat=%0d",
                     d, kw_rv[d], st_rv[d], st_rv[d] ? st_rd[d] : {kw_rd[d], 96'h0}, cyc - acc_cyc[d],
                     e.d, e.kw, e.data, e.lat);
          end
        end
      end
      if ((st_v[d] && st_r[d]) || (kw_v[d] && kw_r[d])) begin
        acc_cnt[d]++;
        prev_acc[d] = acc_cyc[d];
        acc_cyc[d] = cyc;
      end
    end
  end

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endfunction

  function automatic void expect_resp(input int d, input bit kw, input logic [127:0] data, input int lat);
    exp_q.push_back('{d, kw, data, lat});
  endfunction

  task automatic wait_acc(input int d, input int n);
    int t = 0;
    while (acc_cnt[d] < n && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (acc_cnt[d] < n) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: got %0d accepts expected %0d", d, acc_cnt[d], n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit kw, input logic [127:0] data, input logic [127:0] want, input int lat);
    int n;
    expect_resp(d, kw, want, lat);
    n = acc_cnt[d] + 1;
    if (kw) begin
      kw_d[d] = data[127:96];
      kw_v[d] = 1'b1;
    end else begin
      st_d[d] = data;
      st_v[d] = 1'b1;
    end
    wait_acc(d, n);
    if (kw) kw_v[d] = 1'b0;
    else st_v[d] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ctl"}, 128'({st_r[d], kw_r[d], st_rv[d], kw_rv[d]}), 128'h0);
      chk({tag, "_st_data"}, st_rd[d], 128'h0);
      chk({tag, "_kw_data"}, 128'(kw_rd[d]), 128'h0);
      chk({tag, "_busy"}, 128'(busy[d]), 128'h0);
    end
    chk({tag, "_sb_in"}, 128'({sb_in0, sb_in1}), 128'h0);
  endtask

  task automatic tie(input logic [127:0] xs, input logic [127:0] sxs, input logic [127:0] ws, input logic [127:0] sws);
    int n;
    expect_resp(0, 1'b0, sxs, 5);
    expect_resp(0, 1'b1, sws, 2);
    n = acc_cnt[0];
    st_d[0] = xs;
    kw_d[0] = ws[127:96];
    st_v[0] = 1'b1;
    kw_v[0] = 1'b1;
    wait_acc(0, n + 1);
    st_v[0] = 1'b0;
    wait_acc(0, n + 2);
    kw_v[0] = 1'b0;
    chk("tie_kw_gap", 128'(acc_cyc[0] - prev_acc[0]), 128'd5);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    st_v = '{1'b0, 1'b0};
    kw_v = '{1'b0, 1'b0};
    st_d = '{128'h0, 128'h0};
    kw_d = '{32'h0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 128'({st_r[0], kw_r[0], st_r[1], kw_r[1]}), 128'hf);
    send(0, 1'b0, X, SX, 5);
    drain();
    send(0, 1'b1, W, SW, 2);
    drain();
    send(1, 1'b1, W, SW, 5);
    send(1, 1'b0, X, SX, 17);
    drain();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tie(X, SX, W, SW);
    tie(X2, SX2, W2, SW2);
    drain();
    send(0, 1'b0, X, SX, 5);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sb_in_chunk2", 128'(sb_in0), 128'hbbaa9988);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_zero("midrun_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(0, 1'b0, X, SX, 5);
    send(0, 1'b1, W, SW, 2);
    drain();
    chk("busy_cycles", 128'(busy[0]), 128'(BUSY_EXP));
    base = acc_cnt[0];
    repeat (3) expect_resp(0, 1'b0, X2, 5);
    st_d[0] = 128'h52525252525252525252525252525252;
    exp_q.delete();
    repeat (3) expect_resp(0, 1'b0, X2, 5);
    st_v[0] = 1'b1;
    wait_acc(0, base + 1);
    chk("ready_low_run", 128'({st_r[0], kw_r[0]}), 128'h0);
    wait_acc(0, base + 3);
    st_v[0] = 1'b0;
    drain();
    chk("accept_count", 128'(acc_cnt[0] - base), 128'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
